// File: rtl/ram_bank.sv
// DEPTH x WIDTH register RAM with write-first bypass and bulk clear; read latency 0 (REG_OUT=0) or 1 cycle.
// No backpressure: writes arriving while busy is high are dropped; clr_start is ignored while busy.
module ram_bank #(
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = 3,
  parameter bit REG_OUT = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] address,
  input  logic              clr_start,
  output logic [WIDTH-1:0]  out,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr_en;

  assign busy  = (state == S_CLEAR);
  assign wr_en = load && !busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      ptr   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (clr_start) begin
            state <= S_CLEAR;
            ptr   <= '0;
          end
        end
        S_CLEAR: begin
          // ptr returns to 0 on exit rather than by wrapping inside CLEAR
          if (ptr == LAST) begin
            state <= S_IDLE;
            ptr   <= '0;
            done  <= 1'b1;
          end else begin
            ptr <= ptr + ADDR_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (busy) begin
      mem[ptr] <= '0;
    end else if (load) begin
      mem[address] <= in;
    end
  end

  generate
    if (REG_OUT) begin : g_reg_out
      always_ff @(posedge clk) begin
        if (reset)      out <= '0;
        else if (wr_en) out <= in;
        else            out <= mem[address];
      end
    end else begin : g_comb_out
      assign out = mem[address];
    end
  endgenerate

endmodule
